// File: rtl/control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : control_fsm
// Description : Multi-cycle control unit for the 32-bit datapath. It decodes
//               opcode and funct, sequences each instruction and counts
//               retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module control_fsm #(
    parameter int n   = 32,
    parameter int opW = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [n-1:0] instruction,
    input  logic         zero,
    input  logic         memReady,
    output logic         memReq,
    output logic         memWrite,
    output logic         irWrite,
    output logic         pcWrite,
    output logic         pcSrc,
    output logic         jump,
    output logic         memToReg,
    output logic         aluSrc,
    output logic         regDst,
    output logic         writeEnable,
    output logic [3:0]   aluControl,
    output logic [3:0]   state,
    output logic         illegal,
    output logic [n-1:0] retired
);

    // Debug encoding seen on the state port.
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_EXEC    = 4'd2,
        S_ALUWB   = 4'd3,
        S_MEMADDR = 4'd4,
        S_MEMRD   = 4'd5,
        S_MEMWB   = 4'd6,
        S_MEMWR   = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_HALT    = 4'd10,
        S_ILLEGAL = 4'd11
    } state_t;

    localparam logic [opW-1:0] c_op_rtype = opW'(0);
    localparam logic [opW-1:0] c_op_addi  = opW'(1);
    localparam logic [opW-1:0] c_op_lw    = opW'(2);
    localparam logic [opW-1:0] c_op_sw    = opW'(3);
    localparam logic [opW-1:0] c_op_beq   = opW'(4);
    localparam logic [opW-1:0] c_op_j     = opW'(5);
    localparam logic [opW-1:0] c_op_halt  = '1;

    localparam logic [3:0] c_alu_and = 4'b0000;
    localparam logic [3:0] c_alu_or  = 4'b0001;
    localparam logic [3:0] c_alu_add = 4'b0010;
    localparam logic [3:0] c_alu_sub = 4'b0110;
    localparam logic [3:0] c_alu_slt = 4'b0111;

    state_t         r_state;
    state_t         w_next;
    logic           r_illegal;
    logic [n-1:0]   r_retired;
    logic           w_retire;
    logic [opW-1:0] w_opcode;
    logic [5:0]     w_funct;
    logic           w_funct_ok;
    logic [3:0]     w_funct_alu;
    logic [3:0]     w_exec_alu;
    logic           w_is_rtype;
    logic           w_unused;

    assign w_opcode   = instruction[n-1 -: opW];
    assign w_funct    = instruction[5:0];
    assign w_is_rtype = (w_opcode == c_op_rtype);
    assign w_unused   = ^instruction;

    always_comb begin
        w_funct_ok  = 1'b1;
        w_funct_alu = c_alu_add;
        case (w_funct)
            6'b100000: w_funct_alu = c_alu_add;
            6'b100010: w_funct_alu = c_alu_sub;
            6'b100100: w_funct_alu = c_alu_and;
            6'b100101: w_funct_alu = c_alu_or;
            6'b101010: w_funct_alu = c_alu_slt;
            default:   w_funct_ok  = 1'b0;
        endcase
    end

    assign w_exec_alu = w_is_rtype ? w_funct_alu : c_alu_add;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_next == S_ILLEGAL) begin
                r_illegal <= 1'b1;
            end
            if (w_retire) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_retire    = 1'b0;
        memReq      = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        pcWrite     = 1'b0;
        pcSrc       = 1'b0;
        jump        = 1'b0;
        memToReg    = 1'b0;
        aluSrc      = 1'b0;
        regDst      = 1'b0;
        writeEnable = 1'b0;
        aluControl  = c_alu_and;
        case (r_state)
            S_FETCH: begin
                memReq     = 1'b1;
                irWrite    = memReady;
                pcWrite    = memReady;
                aluControl = c_alu_add;
                if (memReady) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                case (w_opcode)
                    c_op_rtype: w_next = w_funct_ok ? S_EXEC : S_ILLEGAL;
                    c_op_addi:  w_next = S_EXEC;
                    c_op_lw:    w_next = S_MEMADDR;
                    c_op_sw:    w_next = S_MEMADDR;
                    c_op_beq:   w_next = S_BRANCH;
                    c_op_j:     w_next = S_JUMP;
                    c_op_halt:  w_next = S_HALT;
                    default:    w_next = S_ILLEGAL;
                endcase
            end
            S_EXEC: begin
                aluSrc     = ~w_is_rtype;
                aluControl = w_exec_alu;
                w_next     = S_ALUWB;
            end
            S_ALUWB: begin
                writeEnable = 1'b1;
                regDst      = w_is_rtype;
                aluControl  = w_exec_alu;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEMADDR: begin
                aluSrc     = 1'b1;
                aluControl = c_alu_add;
                w_next     = (w_opcode == c_op_lw) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                memReq = 1'b1;
                aluSrc = 1'b1;
                if (memReady) begin
                    w_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                writeEnable = 1'b1;
                memToReg    = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEMWR: begin
                memReq   = 1'b1;
                memWrite = 1'b1;
                aluSrc   = 1'b1;
                if (memReady) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_BRANCH: begin
                aluControl = c_alu_sub;
                pcSrc      = zero;
                pcWrite    = zero;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_JUMP: begin
                jump     = 1'b1;
                pcWrite  = 1'b1;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_HALT:    w_next = S_HALT;
            S_ILLEGAL: w_next = S_ILLEGAL;
            default:   w_next = S_FETCH;
        endcase
        // Strobes are forced quiet while reset is held, even mid memory wait.
        if (reset) begin
            memReq      = 1'b0;
            memWrite    = 1'b0;
            irWrite     = 1'b0;
            pcWrite     = 1'b0;
            pcSrc       = 1'b0;
            jump        = 1'b0;
            memToReg    = 1'b0;
            aluSrc      = 1'b0;
            regDst      = 1'b0;
            writeEnable = 1'b0;
            aluControl  = c_alu_and;
        end
    end

    assign state   = r_state;
    assign illegal = r_illegal;
    assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_fsm
// Description : Self-checking bench for control_fsm (vector table, trace model,
//               randomized instruction stream and counter wrap).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_fsm;

    localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, EXEC = 4'd2, ALUWB = 4'd3;
    localparam logic [3:0] MEMADDR = 4'd4, MEMRD = 4'd5, MEMWB = 4'd6, MEMWR = 4'd7;
    localparam logic [3:0] BRANCH = 4'd8, JUMP = 4'd9, HALT = 4'd10, ILLEGAL = 4'd11;
    localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010;
    localparam logic [3:0] A_SUB = 4'b0110, A_SLT = 4'b0111;

    typedef enum int {K_R, K_ADDI, K_LW, K_SW, K_BEQ, K_J, K_HALT, K_BADOP, K_BADFN} kind_t;

    typedef struct packed {
        logic        rdy;
        logic        zd;
        logic        ifetch;
        logic [3:0]  st;
        logic [13:0] strb;
        logic        ill;
        logic        inc;
    } cyc_t;

    typedef struct {
        logic [31:0] ins;
        logic        z;
        int          cyc;
        int          we;
        logic [3:0]  alu;
        int          ret;
        logic        ill;
        logic [3:0]  st;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instruction = '0;
    logic        zero = 1'b0;
    logic        memReady = 1'b0;
    logic        memReq, memWrite, irWrite, pcWrite, pcSrc, jump;
    logic        memToReg, aluSrc, regDst, writeEnable, illegal;
    logic [3:0]  aluControl, state;
    logic [31:0] retired;
    logic [13:0] act_strb;

    logic        w_reset = 1'b1;
    logic [7:0]  w_instr = 8'h28;
    logic        w_zero = 1'b0;
    logic        w_rdy = 1'b1;
    logic        wr_memReq, wr_memWrite, wr_irWrite, wr_pcWrite, wr_pcSrc, wr_jump;
    logic        wr_memToReg, wr_aluSrc, wr_regDst, wr_writeEnable, wr_illegal;
    logic [3:0]  wr_aluControl, wr_state;
    logic [7:0]  wr_retired;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] m_ret = '0;
    logic [31:0] cur_instr = '0;
    cyc_t        trace[$];
    vec_t        vt[14];
    logic [5:0]  fn_tab[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    logic [3:0]  alu_tab[5] = '{A_ADD, A_SUB, A_AND, A_OR, A_SLT};

    always #5 clk = ~clk;

    control_fsm #(.n(32), .opW(5)) dut (
        .clk(clk), .reset(reset), .instruction(instruction), .zero(zero),
        .memReady(memReady), .memReq(memReq), .memWrite(memWrite),
        .irWrite(irWrite), .pcWrite(pcWrite), .pcSrc(pcSrc), .jump(jump),
        .memToReg(memToReg), .aluSrc(aluSrc), .regDst(regDst),
        .writeEnable(writeEnable), .aluControl(aluControl), .state(state),
        .illegal(illegal), .retired(retired)
    );

    control_fsm #(.n(8), .opW(5)) u_wrap (
        .clk(clk), .reset(w_reset), .instruction(w_instr), .zero(w_zero),
        .memReady(w_rdy), .memReq(wr_memReq), .memWrite(wr_memWrite),
        .irWrite(wr_irWrite), .pcWrite(wr_pcWrite), .pcSrc(wr_pcSrc),
        .jump(wr_jump), .memToReg(wr_memToReg), .aluSrc(wr_aluSrc),
        .regDst(wr_regDst), .writeEnable(wr_writeEnable),
        .aluControl(wr_aluControl), .state(wr_state), .illegal(wr_illegal),
        .retired(wr_retired)
    );

    assign act_strb = {memReq, memWrite, irWrite, pcWrite, pcSrc, jump,
                       memToReg, aluSrc, regDst, writeEnable, aluControl};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [31:0] ins(input logic [4:0] op, input logic [5:0] fn);
        return {op, 21'h15A5A, fn};
    endfunction

    function automatic logic [13:0] sb(input logic rq, input logic wr, input logic ir,
                                       input logic pw, input logic ps, input logic jp,
                                       input logic m2r, input logic as, input logic rd,
                                       input logic we, input logic [3:0] alu);
        return {rq, wr, ir, pw, ps, jp, m2r, as, rd, we, alu};
    endfunction

    function automatic logic legal_fn(input logic [5:0] f);
        for (int i = 0; i < 5; i++) if (fn_tab[i] == f) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] mk(input kind_t k, input int fi);
        logic [31:0] r;
        logic [5:0]  f;
        r = $urandom;
        case (k)
            K_R:     begin r[31:27] = 5'd0; r[5:0] = fn_tab[fi]; end
            K_ADDI:  r[31:27] = 5'd1;
            K_LW:    r[31:27] = 5'd2;
            K_SW:    r[31:27] = 5'd3;
            K_BEQ:   r[31:27] = 5'd4;
            K_J:     r[31:27] = 5'd5;
            K_HALT:  r[31:27] = 5'h1F;
            K_BADOP: r[31:27] = 5'($urandom_range(6, 30));
            default: begin
                r[31:27] = 5'd0;
                do f = 6'($urandom); while (legal_fn(f));
                r[5:0] = f;
            end
        endcase
        return r;
    endfunction

    task automatic push(input logic [3:0] st, input logic [13:0] s, input logic rdy,
                        input logic inc, input logic ill, input logic zd);
        cyc_t e;
        e.rdy = rdy; e.zd = zd; e.ifetch = (st == FETCH); e.st = st;
        e.strb = s; e.ill = ill; e.inc = inc;
        trace.push_back(e);
    endtask

    // Expected cycle list of one instruction: wf fetch waits, wm memory waits
    // (or hold length for HALT/ILLEGAL).
    task automatic build(input kind_t k, input logic [3:0] alu, input logic z,
                         input int wf, input int wm);
        logic [13:0] s;
        for (int i = 0; i < wf; i++) push(FETCH, sb(1,0,0,0,0,0,0,0,0,0,A_ADD), 0, 0, 0, rb());
        push(FETCH, sb(1,0,1,1,0,0,0,0,0,0,A_ADD), 1, 0, 0, rb());
        push(DECODE, 14'd0, rb(), 0, 0, rb());
        case (k)
            K_R, K_ADDI: begin
                push(EXEC, sb(0,0,0,0,0,0,0,k == K_ADDI,0,0,alu), rb(), 0, 0, rb());
                push(ALUWB, sb(0,0,0,0,0,0,0,0,k == K_R,1,alu), rb(), 1, 0, rb());
            end
            K_LW: begin
                s = sb(1,0,0,0,0,0,0,1,0,0,A_AND);
                push(MEMADDR, sb(0,0,0,0,0,0,0,1,0,0,A_ADD), rb(), 0, 0, rb());
                for (int i = 0; i < wm; i++) push(MEMRD, s, 0, 0, 0, rb());
                push(MEMRD, s, 1, 0, 0, rb());
                push(MEMWB, sb(0,0,0,0,0,0,1,0,0,1,A_AND), rb(), 1, 0, rb());
            end
            K_SW: begin
                s = sb(1,1,0,0,0,0,0,1,0,0,A_AND);
                push(MEMADDR, sb(0,0,0,0,0,0,0,1,0,0,A_ADD), rb(), 0, 0, rb());
                for (int i = 0; i < wm; i++) push(MEMWR, s, 0, 0, 0, rb());
                push(MEMWR, s, 1, 1, 0, rb());
            end
            K_BEQ:  push(BRANCH, sb(0,0,0,z,z,0,0,0,0,0,A_SUB), rb(), 1, 0, z);
            K_J:    push(JUMP, sb(0,0,0,1,0,1,0,0,0,0,A_AND), rb(), 1, 0, rb());
            K_HALT: for (int i = 0; i < wm; i++) push(HALT, 14'd0, rb(), 0, 0, rb());
            default: for (int i = 0; i < wm; i++) push(ILLEGAL, 14'd0, rb(), 0, 1, rb());
        endcase
    endtask

    task automatic run_n(input int cnt);
        for (int i = 0; i < cnt && trace.size() > 0; i++) begin
            cyc_t e;
            e = trace.pop_front();
            @(negedge clk);
            memReady = e.rdy;
            zero = e.zd;
            instruction = e.ifetch ? $urandom : cur_instr;
            #1;
            check("cycle", 64'({state, act_strb, illegal}), 64'({e.st, e.strb, e.ill}));
            check("retired", 64'(retired), 64'(m_ret));
            if (e.inc) m_ret = m_ret + 1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        memReady = rb();
        #1;
        check("reset_strobes", 64'(act_strb), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        memReady = 1'b0;
        check("post_reset", 64'({state, illegal, retired}), 64'({FETCH, 1'b0, 32'd0}));
        m_ret = '0;
        trace.delete();
    endtask

    task automatic settle(input string name, input logic [31:0] exp_ret);
        @(posedge clk);
        #1;
        check(name, 64'({state, retired}), 64'({FETCH, exp_ret}));
    endtask

    task automatic one(input kind_t k, input logic [31:0] ir, input logic [3:0] alu,
                       input logic z, input int wf, input int wm);
        cur_instr = ir;
        build(k, alu, z, wf, wm);
        run_n(100);
    endtask

    initial begin
        vt[0]  = '{ins(5'd0, 6'h20), 1'b0, 4, 1, A_ADD, 1, 1'b0, FETCH};
        vt[1]  = '{ins(5'd0, 6'h22), 1'b0, 4, 1, A_SUB, 1, 1'b0, FETCH};
        vt[2]  = '{ins(5'd0, 6'h24), 1'b0, 4, 1, A_AND, 1, 1'b0, FETCH};
        vt[3]  = '{ins(5'd0, 6'h25), 1'b0, 4, 1, A_OR,  1, 1'b0, FETCH};
        vt[4]  = '{ins(5'd0, 6'h2A), 1'b0, 4, 1, A_SLT, 1, 1'b0, FETCH};
        vt[5]  = '{ins(5'd1, 6'h07), 1'b0, 4, 1, A_ADD, 1, 1'b0, FETCH};
        vt[6]  = '{ins(5'd2, 6'h00), 1'b0, 5, 1, A_AND, 1, 1'b0, FETCH};
        vt[7]  = '{ins(5'd3, 6'h00), 1'b0, 4, 0, A_AND, 1, 1'b0, FETCH};
        vt[8]  = '{ins(5'd4, 6'h00), 1'b1, 3, 0, A_SUB, 1, 1'b0, FETCH};
        vt[9]  = '{ins(5'd4, 6'h00), 1'b0, 3, 0, A_SUB, 1, 1'b0, FETCH};
        vt[10] = '{ins(5'd5, 6'h00), 1'b0, 3, 0, A_AND, 1, 1'b0, FETCH};
        vt[11] = '{ins(5'h1F, 6'h00), 1'b0, 12, 0, A_AND, 0, 1'b0, HALT};
        vt[12] = '{ins(5'b01010, 6'h20), 1'b0, 12, 0, A_AND, 0, 1'b1, ILLEGAL};
        vt[13] = '{ins(5'd0, 6'b000111), 1'b0, 12, 0, A_AND, 0, 1'b1, ILLEGAL};

        // Table: each vector from reset with memReady held high.
        for (int i = 0; i < 14; i++) begin
            int cnt, wec;
            logic [3:0] la;
            bit done;
            logic [31:0] a, x;
            do_reset();
            cnt = 0; wec = 0; la = '0; done = 0;
            for (int c = 0; c < 12 && !done; c++) begin
                @(negedge clk);
                memReady = 1'b1;
                instruction = vt[i].ins;
                zero = vt[i].z;
                #1;
                if (c > 0 && state == FETCH) done = 1;
                else begin
                    cnt++;
                    wec += int'(writeEnable);
                    la = aluControl;
                end
            end
            a = {8'(cnt), 4'(wec), la, retired[7:0], illegal, 3'b0, state};
            x = {8'(vt[i].cyc), 4'(vt[i].we), vt[i].alu, 8'(vt[i].ret), vt[i].ill, 3'b0, vt[i].st};
            check($sformatf("vec%0d", i), 64'(a), 64'(x));
        end

        do_reset();
        one(K_R, ins(5'd0, 6'h20), A_ADD, 1'b0, 0, 0);
        settle("add_retire", 32'd1);

        do_reset();
        one(K_LW, ins(5'd2, 6'h11), A_AND, 1'b0, 0, 3);
        settle("lw_wait_retire", 32'd1);

        do_reset();
        one(K_BEQ, ins(5'd4, 6'h00), A_SUB, 1'b1, 0, 0);
        one(K_BEQ, ins(5'd4, 6'h00), A_SUB, 1'b0, 1, 0);
        settle("beq_retire", 32'd2);

        do_reset();
        one(K_SW, ins(5'd3, 6'h00), A_AND, 1'b0, 0, 1);
        one(K_J, ins(5'd5, 6'h00), A_AND, 1'b0, 0, 0);
        settle("sw_j_retire", 32'd2);

        do_reset();
        one(K_BADOP, ins(5'b01010, 6'h00), A_AND, 1'b0, 0, 10);
        do_reset();
        one(K_BADFN, ins(5'd0, 6'b000111), A_AND, 1'b0, 0, 10);
        do_reset();

        // Reset during a read wait must abort the access.
        one(K_R, ins(5'd0, 6'h22), A_SUB, 1'b0, 0, 0);
        cur_instr = ins(5'd2, 6'h00);
        build(K_LW, A_AND, 1'b0, 0, 5);
        run_n(5);
        check("mid_wait_state", 64'({state, memReq}), 64'({MEMRD, 1'b1}));
        do_reset();

        // Randomized instruction stream against the trace model.
        repeat (300) begin
            int r, fi;
            kind_t k;
            logic z;
            r = $urandom_range(0, 19);
            k = (r < 16) ? kind_t'(r % 6) : (r == 16) ? K_HALT : (r == 17) ? K_BADOP : K_BADFN;
            fi = $urandom_range(0, 4);
            z = rb();
            one(k, mk(k, fi), (k == K_R) ? alu_tab[fi] : A_ADD, z,
                $urandom_range(0, 3), (k >= K_HALT) ? $urandom_range(3, 6) : $urandom_range(0, 3));
            if (k >= K_HALT) do_reset();
        end

        // Counter wrap on the narrow instance: 256 jumps.
        @(posedge clk);
        #1;
        w_reset = 1'b0;
        repeat (255 * 3) @(posedge clk);
        #1;
        check("wrap_pre", 64'({wr_state, wr_retired}), 64'({FETCH, 8'd255}));
        repeat (3) @(posedge clk);
        #1;
        check("wrap", 64'({wr_state, wr_retired}), 64'({FETCH, 8'd0}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
